key_conditioner_bank: RTL and testbench
=======================================

Name: key_conditioner_bank

Overview:
Parametrised multi-channel front end that replaces per-button debounce/one-pulse pairs. Synchronises N_CH raw buttons/switches and debounces them on a shared tick. Emits stable levels, press and release pulses, and optional auto-repeat pulses. Also priority-encodes the fired key for the player controller. Sits between board pins and Player_control on the 100 MHz system clock; no divided clocks.

Parameters:
N_CH, 16, number of input channels (1..32)
TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz); >=2
DEB_TICKS, 10, consecutive differing tick samples needed to flip a level; >=1
REPEAT_DELAY, 500, ticks from press to first repeat pulse; >=1
REPEAT_PERIOD, 100, ticks between subsequent repeat pulses; >=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
raw_i  in  N_CH  unsynchronised button/switch inputs
repeat_en_i  in  N_CH  per-channel auto-repeat enable
level_o  out  N_CH  debounced level
press_o  out  N_CH  1-cycle pulse on debounced 0->1
release_o  out  N_CH  1-cycle pulse on debounced 1->0
fire_o  out  N_CH  press_o OR repeat pulse, 1 cycle
any_fire_o  out  1  OR of fire_o
fire_code_o  out  $clog2(N_CH) (min 1)  lowest index set in fire_o; 0 when none
tick_o  out  1  shared sample strobe, 1 cycle every TICK_DIV clks

Behaviour:
- Reset (async assert; sync flops cleared): all outputs 0, all counters 0, synchroniser 0, repeat phase DELAY. On deassert, prescaler restarts at 0.
- Sync: 2-FF synchroniser per channel; sync value = second stage.
- Prescaler: counts 0..TICK_DIV-1. tick asserted for the single cycle where count == TICK_DIV-1, then wraps to 0.
- Debounce, per channel, evaluated only on tick cycles:
  - sync == level: cnt <= 0.
  - sync != level and cnt == DEB_TICKS-1: level <= sync, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Glitches shorter than DEB_TICKS ticks never change level.
- Edge pulses: press_o/release_o are registered.
  - Each is high for exactly the first clk cycle in which level_o shows the new value.
  - It deasserts the next cycle.
- Repeat FSM, per channel, states DELAY/RATE with rcnt:
  - Cleared to DELAY/0 on press, whenever level=0, or whenever repeat_en_i=0.
  - On tick with level=1 and repeat_en=1:
    - DELAY: if rcnt == REPEAT_DELAY-1, pulse, rcnt <= 0, go to RATE; else rcnt++.
    - RATE: if rcnt == REPEAT_PERIOD-1, pulse, rcnt <= 0; else rcnt++.
  - The repeat pulse is registered into fire_o in the cycle after the tick.
  - It can never coincide with press_o, because a repeat needs at least one tick after the press.
- fire_o/any_fire_o/fire_code_o: registered together from the same next-state terms, so they align with press_o. Multiple channels may fire in one cycle; fire_code_o reports the lowest index only.
- Latency raw->level: 2 clks sync + up to TICK_DIV clks to the next tick + DEB_TICKS ticks.
- Input held high through reset: treated as a new press after DEB_TICKS ticks (press_o fires).
- repeat_en_i dropped mid-hold: repeats stop immediately; re-raising restarts the full REPEAT_DELAY.
- Counter widths are $clog2 of their limit (min 1). No counter exceeds its limit-1.

Decomposition:
- Shared package key_pkg: default parameter constants, clog2-min-1 width helper, DELAY/RATE state encoding.
- Sub-module key_channel: one per channel via generate. It holds sync, debounce, edge and repeat logic and takes tick as input.
- Top level holds the prescaler, the OR reduction and the priority encoder.

Test Plan (TICK_DIV=4, DEB_TICKS=3, REPEAT_DELAY=5, REPEAT_PERIOD=2, N_CH=4):
- Reset mid-count: raw_i[0]=1 for 2 ticks, assert reset -> all outputs 0 at once; after release and 3 ticks of raw high -> press_o[0] one cycle, level_o[0]=1.
- Glitch: raw_i[1] high for 2 ticks then low -> level_o[1], press_o[1], fire_o[1] stay 0.
- Press/release: raw_i[2] high 10 ticks then low, repeat_en=0 -> exactly one press_o[2] and one release_o[2]; fire_o[2] pulses once.
- Auto-repeat: repeat_en[3]=1, hold raw_i[3] 20 ticks -> fire_o[3] at press, +5 ticks, then every 2 ticks; none after release.
- Simultaneous: raw_i[1] and raw_i[3] rise same cycle -> press_o=4'b1010, fire_code_o=1, any_fire_o=1 for one cycle.
- Repeat disable mid-hold: drop repeat_en[3] during RATE -> no further fire_o[3]; re-enable -> next fire after 5 ticks.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants, width helper and repeat-state encoding for the key conditioner bank.
package key_pkg;

  localparam int unsigned N_CH_DEF          = 16;
  localparam int unsigned TICK_DIV_DEF      = 100000;
  localparam int unsigned DEB_TICKS_DEF     = 10;
  localparam int unsigned REPEAT_DELAY_DEF  = 500;
  localparam int unsigned REPEAT_PERIOD_DEF = 100;

  typedef enum logic {
    RPT_DELAY = 1'b0,
    RPT_RATE  = 1'b1
  } rpt_state_t;

  // Bits needed to hold limit-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One conditioned input: 2-FF synchroniser, tick-sampled debounce, edge pulses, auto-repeat.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEB_TICKS     = DEB_TICKS_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  input  logic tick,
  output logic level,
  output logic press,
  output logic rel,
  output logic fire_nxt
);

  localparam int unsigned DW = clog2_min1(DEB_TICKS);
  localparam int unsigned RW = clog2_min1((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic            sync1, sync2;
  logic [DW-1:0]   cnt, cnt_nxt;
  logic            level_nxt;
  logic            flip;
  rpt_state_t      state, state_nxt;
  logic [RW-1:0]   rcnt, rcnt_nxt;
  logic            rep_hit;

  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    flip      = 1'b0;
    if (tick) begin
      if (sync2 == level) begin
        cnt_nxt = '0;
      end else if (cnt == DEB_LAST) begin
        level_nxt = sync2;
        cnt_nxt   = '0;
        flip      = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // A press always happens while level is still 0, so the !level clear covers it.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rep_hit   = 1'b0;
    if (!level || !repeat_en) begin
      state_nxt = RPT_DELAY;
      rcnt_nxt  = '0;
    end else if (tick) begin
      case (state)
        RPT_DELAY: begin
          if (rcnt == DLY_LAST) begin
            rep_hit   = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = RPT_RATE;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        RPT_RATE: begin
          if (rcnt == PER_LAST) begin
            rep_hit  = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = RPT_DELAY;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign fire_nxt = (flip & sync2) | rep_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
      state <= RPT_DELAY;
      rcnt  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_nxt;
      cnt   <= cnt_nxt;
      press <= flip & sync2;
      rel   <= flip & ~sync2;
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

endmodule

// File: rtl/key_conditioner_bank.sv
// Multi-channel button front end: shared sample prescaler, per-channel conditioning, fire encoder.
module key_conditioner_bank
  import key_pkg::*;
#(
  parameter int unsigned N_CH          = N_CH_DEF,
  parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
  parameter int unsigned DEB_TICKS     = DEB_TICKS_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_CH-1:0]                raw_i,
  input  logic [N_CH-1:0]                repeat_en_i,
  output logic [N_CH-1:0]                level_o,
  output logic [N_CH-1:0]                press_o,
  output logic [N_CH-1:0]                release_o,
  output logic [N_CH-1:0]                fire_o,
  output logic                           any_fire_o,
  output logic [clog2_min1(N_CH)-1:0]    fire_code_o,
  output logic                           tick_o
);

  localparam int unsigned CW = clog2_min1(N_CH);
  localparam int unsigned PW = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]   pcnt;
  logic [N_CH-1:0] fire_nxt;
  logic [CW-1:0]   code_nxt;
  logic            found;

  assign tick_o = (pcnt == P_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pcnt <= '0;
    else       pcnt <= tick_o ? '0 : pcnt + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    key_channel #(
      .DEB_TICKS     (DEB_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw_i[g]),
      .repeat_en (repeat_en_i[g]),
      .tick      (tick_o),
      .level     (level_o[g]),
      .press     (press_o[g]),
      .rel       (release_o[g]),
      .fire_nxt  (fire_nxt[g])
    );
  end

  always_comb begin
    code_nxt = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && fire_nxt[i]) begin
        code_nxt = CW'(i);
        found    = 1'b1;
      end
    end
  end

  // Registered from the same next-state terms as press_o so all fire outputs line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_o      <= '0;
      any_fire_o  <= 1'b0;
      fire_code_o <= '0;
    end else begin
      fire_o      <= fire_nxt;
      any_fire_o  <= |fire_nxt;
      fire_code_o <= code_nxt;
    end
  end

endmodule

// File: tb/tb_key_conditioner_bank.sv
// Scoreboard bench for key_conditioner_bank: stimulus pushes expected events, monitor pops on output activity.
module tb_key_conditioner_bank;

  localparam int unsigned N_CH          = 4;
  localparam int unsigned TICK_DIV      = 4;
  localparam int unsigned DEB_TICKS     = 3;
  localparam int unsigned REPEAT_DELAY  = 5;
  localparam int unsigned REPEAT_PERIOD = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      raw_i, repeat_en_i;
  logic [3:0]      level_o, press_o, release_o, fire_o;
  logic            any_fire_o, tick_o;
  logic [1:0]      fire_code_o;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] fire;
    logic [3:0] level;
    logic [1:0] code;
  } ev_t;

  ev_t expq[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc;

  key_conditioner_bank #(
    .N_CH          (N_CH),
    .TICK_DIV      (TICK_DIV),
    .DEB_TICKS     (DEB_TICKS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_i       (raw_i),
    .repeat_en_i (repeat_en_i),
    .level_o     (level_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .fire_o      (fire_o),
    .any_fire_o  (any_fire_o),
    .fire_code_o (fire_code_o),
    .tick_o      (tick_o)
  );

  always #5 clk = ~clk;

  // Bench time base: posedges since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] f, input logic [3:0] l, input logic [1:0] code);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.fire = f; e.level = l; e.code = code;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, n);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (((press_o | release_o | fire_o) != 4'b0000) || any_fire_o)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc %0d press %b release %b fire %b code %0d, expected no event",
                 cyc, press_o, release_o, fire_o, fire_code_o);
      end else begin
        mon_e = expq.pop_front();
        if (cyc != mon_e.cyc || press_o !== mon_e.press || release_o !== mon_e.rel ||
            fire_o !== mon_e.fire || level_o !== mon_e.level || fire_code_o !== mon_e.code ||
            any_fire_o !== (mon_e.fire != 4'b0000)) begin
          errors++;
          $display("FAIL event: got/exp cyc %0d/%0d press %b/%b release %b/%b fire %b/%b level %b/%b code %0d/%0d any %b",
                   cyc, mon_e.cyc, press_o, mon_e.press, release_o, mon_e.rel, fire_o, mon_e.fire,
                   level_o, mon_e.level, fire_code_o, mon_e.code, any_fire_o);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    raw_i       = 4'b0000;
    repeat_en_i = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {level_o, press_o, release_o, fire_o, any_fire_o, fire_code_o, tick_o}, 64'd0);
    reset = 1'b0;

    // Prescaler phase: tick in every cycle with cyc%4==3.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tick_phase", tick_o, (cyc % 4) == 3);
    end

    // Reset mid-debounce: two ticks counted, then reset; restart must need the full three ticks.
    wait_cyc(8);
    raw_i[0] = 1'b1;
    wait_cyc(17);
    reset = 1'b1;
    #1;
    chk("reset_async", {level_o, press_o, release_o, fire_o, any_fire_o, fire_code_o, tick_o}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    push_ev(12, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'd0);
    wait_cyc(14);
    chk("level0_after_press", level_o[0], 1'b1);

    // Glitch of two ticks on channel 1.
    wait_cyc(20);
    raw_i[1] = 1'b1;
    wait_cyc(28);
    raw_i[1] = 1'b0;
    wait_cyc(48);
    chk("glitch_level1", level_o[1], 1'b0);

    // Press/release on channel 2 without repeat.
    raw_i[2] = 1'b1;
    push_ev(60,  4'b0100, 4'b0000, 4'b0100, 4'b0101, 2'd2);
    push_ev(100, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 2'd0);
    wait_cyc(88);
    raw_i[2] = 1'b0;

    // Auto-repeat on channel 3: press at 116, first repeat +20 clks, then every 8.
    wait_cyc(104);
    repeat_en_i = 4'b1000;
    raw_i[3]    = 1'b1;
    push_ev(116, 4'b1000, 4'b0000, 4'b1000, 4'b1001, 2'd3);
    for (int k = 0; k < 8; k++)
      push_ev(136 + 8 * k, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 2'd3);
    push_ev(196, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 2'd0);
    wait_cyc(184);
    raw_i[3] = 1'b0;
    wait_cyc(200);
    repeat_en_i = 4'b0000;
    chk("level3_after_release", level_o[3], 1'b0);

    // Simultaneous press on channels 1 and 3.
    wait_cyc(204);
    raw_i[1] = 1'b1;
    raw_i[3] = 1'b1;
    push_ev(216, 4'b1010, 4'b0000, 4'b1010, 4'b1011, 2'd1);
    push_ev(236, 4'b0000, 4'b1010, 4'b0000, 4'b0001, 2'd0);
    wait_cyc(224);
    raw_i[1] = 1'b0;
    raw_i[3] = 1'b0;

    // Repeat disabled during RATE, then re-enabled: full delay again.
    wait_cyc(244);
    repeat_en_i = 4'b1000;
    raw_i[3]    = 1'b1;
    push_ev(256, 4'b1000, 4'b0000, 4'b1000, 4'b1001, 2'd3);
    push_ev(276, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 2'd3);
    push_ev(284, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 2'd3);
    push_ev(316, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 2'd3);
    push_ev(324, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 2'd3);
    push_ev(328, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 2'd0);
    wait_cyc(286);
    repeat_en_i = 4'b0000;
    wait_cyc(296);
    repeat_en_i = 4'b1000;
    wait_cyc(316);
    raw_i[3] = 1'b0;

    wait_cyc(360);
    chk("queue_drained", expq.size(), 64'd0);
    chk("final_level", level_o, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
